mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have the port clk, an input of width 1, as its single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port rst, an input of width 1: asynchronous, active-low reset.
REQ-003 The block SHALL have the following decode inputs: Op (input, 6 bits, instruction opcode from IR) and Func (input, 6 bits, R-type function field).
REQ-004 The block SHALL have the following status inputs: Zero (input, 1 bit, ALU result equals zero) and mem_ready (input, 1 bit, memory completes the current access this cycle).
REQ-005 The block SHALL have the following control outputs, each 1 bit: PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg and ALUSrcA.
REQ-006 The block SHALL have the following control outputs:
- ALUSrcB: output, 2 bits; 0 = reg B, 1 = constant 4, 2 = extended immediate.
- ALUop: output, 5 bits; ALU_* encodings.
- Ext: output, 2 bits; EXT_* encodings.
- PCSrc: output, 2 bits; NPC_* encodings.
REQ-007 The block SHALL have the following status outputs: state (output, 3 bits, current FSM state), instr_done (output, 1 bit, one-cycle pulse on instruction retire) and ill_op (output, 1 bit, one-cycle pulse on unsupported opcode or funct).

Function
REQ-008 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5 and JUMP=6; encoding 7 is unreachable and SHALL return to FETCH on the next edge.
REQ-009 In every state, any output not listed for that state SHALL be 0; ALUop defaults to ALU_NOP, Ext to EXT_ZERO and PCSrc to NPC_PLUS4.
REQ-010 FETCH SHALL behave as follows:
- Outputs: MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUop=ALU_ADD.
- IRWrite and PCWrite SHALL be 1 only in the cycle mem_ready=1.
- The FSM SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-011 DECODE SHALL latch Op and Func into internal registers; all later states use only the latched values.
REQ-012 DECODE SHALL select the next state as follows:
- R-type with a supported funct (ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV), ADDI, LW or SW -> EXEC.
- BEQ -> BRANCH.
- J or JAL -> JUMP.
- Anything else -> FETCH, with ill_op=1 for that cycle.
REQ-013 EXEC SHALL drive ALUSrcA=1.
- R-type: ALUSrcB=0 and ALUop mapped from funct; variable shifts map to the same ALUop as the fixed shifts.
- ADDI, LW and SW: ALUSrcB=2, ALUop=ALU_ADD, Ext=EXT_SIGNED.
- Next state: LW/SW -> MEM; R-type/ADDI -> WB.
REQ-014 MEM SHALL drive MemRead=1 for LW or MemWrite=1 for SW, held while mem_ready=0.
- When mem_ready=1: LW -> WB; SW -> FETCH with instr_done=1.
REQ-015 WB SHALL drive RegWrite=1 for exactly one cycle.
- R-type: RegDst=1, MemtoReg=0.
- ADDI: RegDst=0, MemtoReg=0.
- LW: RegDst=0, MemtoReg=1.
- Next state: FETCH, with instr_done=1.
REQ-016 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=0, ALUop=ALU_SUB, Ext=EXT_SIGNED, PCSrc=NPC_BRANCH, and PCWrite=Zero.
- Next state: FETCH, with instr_done=1.
REQ-017 JUMP SHALL drive PCWrite=1, with PCSrc=NPC_JUMP for J and NPC_JAL for JAL; RegWrite=1 only for JAL.
- Next state: FETCH, with instr_done=1.
REQ-018 With mem_ready constantly 1, cycles from entering FETCH to the retire pulse SHALL be: R/ADDI 4, LW 5, SW 4, BEQ 3, J/JAL 3; each cycle of mem_ready=0 in FETCH or MEM adds exactly one cycle.
REQ-019 Control outputs SHALL be combinational functions of the current state, the latched Op/Func, Zero and mem_ready only; there SHALL be no combinational path from Op or Func to the outputs except in DECODE.
REQ-020 Op/Func changing outside DECODE SHALL NOT affect outputs or transitions.

Reset
REQ-021 rst=0 SHALL immediately force state=FETCH and clear the latched Op/Func to 0, regardless of clk.
REQ-022 While in reset, all outputs SHALL read their FETCH-state values, with IRWrite=0, PCWrite=0, instr_done=0 and ill_op=0.
REQ-023 Reset asserted mid-instruction, including during a stalled MEM access, SHALL abandon the instruction with no further RegWrite, MemWrite or PCWrite.
REQ-024 After rst rises, the first active edge SHALL evaluate FETCH normally.

Verification
REQ-025 With mem_ready=1, the bench SHALL run ADD (Op=0, Func=0x20) and expect states 0,1,2,4,0, ALUop=ALU_ADD in EXEC, RegWrite=1 and RegDst=1 in WB only, and instr_done on cycle 4.
REQ-026 The bench SHALL run LW with mem_ready low for 2 cycles in MEM and expect MemRead=1 held for 3 cycles, then WB with MemtoReg=1 and RegDst=0, for a total of 7 cycles.
REQ-027 The bench SHALL run BEQ twice: Zero=1 -> PCWrite=1 with PCSrc=NPC_BRANCH in BRANCH; Zero=0 -> PCWrite=0; both retire in 3 cycles.
REQ-028 The bench SHALL run JAL and expect, in JUMP, PCWrite=1, RegWrite=1 and PCSrc=NPC_JAL; J SHALL give the same with RegWrite=0 and PCSrc=NPC_JUMP.
REQ-029 The bench SHALL present Op=0x3F in DECODE and expect ill_op pulsed for 1 cycle, a return to FETCH, and no write enables asserted.
REQ-030 The bench SHALL assert rst=0 mid-cycle during a stalled SW in MEM and expect state=0 and MemWrite=0 immediately, asynchronously; after release, a normal fetch.

Source files
------------

// File: rtl/mc_control_if.sv
// Decode/status inputs and control/status outputs of the multicycle controller.
// The slave modport is the controller's view; master is the datapath/bench view.
interface mc_control_if;
  logic [5:0] Op;
  logic [5:0] Func;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [4:0] ALUop;
  logic [1:0] Ext;
  logic [1:0] PCSrc;
  logic [2:0] state;
  logic       instr_done;
  logic       ill_op;

  modport slave (
    input  Op, Func, Zero, mem_ready,
    output PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ALUop, Ext, PCSrc, state, instr_done, ill_op
  );

  modport master (
    output Op, Func, Zero, mem_ready,
    input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ALUop, Ext, PCSrc, state, instr_done, ill_op
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP.
// Outputs decode the current state and the opcode/funct latched in DECODE.
module mc_control (
  input  logic         clk,
  input  logic         rst,
  mc_control_if.slave  bus
);

  localparam int unsigned OP_W   = 6;
  localparam int unsigned ALU_W  = 5;
  localparam int unsigned SEL_W  = 2;

  localparam logic [OP_W-1:0] OP_R    = 6'h00;
  localparam logic [OP_W-1:0] OP_J    = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OP_W-1:0] OP_LW   = 6'h23;
  localparam logic [OP_W-1:0] OP_SW   = 6'h2B;

  localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
  localparam logic [OP_W-1:0] FN_SRA  = 6'h03;
  localparam logic [OP_W-1:0] FN_SLLV = 6'h04;
  localparam logic [OP_W-1:0] FN_SRLV = 6'h06;
  localparam logic [OP_W-1:0] FN_SRAV = 6'h07;
  localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [OP_W-1:0] FN_SLTU = 6'h2B;

  localparam logic [ALU_W-1:0] ALU_NOP  = 5'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'd2;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'd3;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'd4;
  localparam logic [ALU_W-1:0] ALU_XOR  = 5'd5;
  localparam logic [ALU_W-1:0] ALU_NOR  = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SLT  = 5'd7;
  localparam logic [ALU_W-1:0] ALU_SLTU = 5'd8;
  localparam logic [ALU_W-1:0] ALU_SLL  = 5'd9;
  localparam logic [ALU_W-1:0] ALU_SRL  = 5'd10;
  localparam logic [ALU_W-1:0] ALU_SRA  = 5'd11;
  localparam logic [ALU_W-1:0] ALU_ADDU = 5'd12;
  localparam logic [ALU_W-1:0] ALU_SUBU = 5'd13;

  localparam logic [SEL_W-1:0] EXT_ZERO   = 2'd0;
  localparam logic [SEL_W-1:0] EXT_SIGNED = 2'd1;

  localparam logic [SEL_W-1:0] NPC_PLUS4  = 2'd0;
  localparam logic [SEL_W-1:0] NPC_BRANCH = 2'd1;
  localparam logic [SEL_W-1:0] NPC_JUMP   = 2'd2;
  localparam logic [SEL_W-1:0] NPC_JAL    = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [OP_W-1:0] func_q, func_d;

  logic             pc_write_c, ir_write_c, mem_read_c, mem_write_c;
  logic             reg_write_c, reg_dst_c, mem_to_reg_c, alu_src_a_c;
  logic [SEL_W-1:0] alu_src_b_c, ext_c, pc_src_c;
  logic [ALU_W-1:0] alu_op_c;
  logic             instr_done_c, ill_op_c;

  // Funct-to-ALU map; NOP doubles as the "unsupported funct" marker.
  function automatic logic [ALU_W-1:0] funct_alu(input logic [OP_W-1:0] fn);
    case (fn)
      FN_ADD:          funct_alu = ALU_ADD;
      FN_ADDU:         funct_alu = ALU_ADDU;
      FN_SUB:          funct_alu = ALU_SUB;
      FN_SUBU:         funct_alu = ALU_SUBU;
      FN_AND:          funct_alu = ALU_AND;
      FN_OR:           funct_alu = ALU_OR;
      FN_XOR:          funct_alu = ALU_XOR;
      FN_NOR:          funct_alu = ALU_NOR;
      FN_SLT:          funct_alu = ALU_SLT;
      FN_SLTU:         funct_alu = ALU_SLTU;
      FN_SLL, FN_SLLV: funct_alu = ALU_SLL;
      FN_SRL, FN_SRLV: funct_alu = ALU_SRL;
      FN_SRA, FN_SRAV: funct_alu = ALU_SRA;
      default:         funct_alu = ALU_NOP;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      func_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    func_d       = func_q;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'd0;
    alu_op_c     = ALU_NOP;
    ext_c        = EXT_ZERO;
    pc_src_c     = NPC_PLUS4;
    instr_done_c = 1'b0;
    ill_op_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'd1;
        alu_op_c    = ALU_ADD;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      // Only state that looks at the live Op/Func inputs.
      S_DECODE: begin
        op_d   = bus.Op;
        func_d = bus.Func;
        if ((bus.Op == OP_R && funct_alu(bus.Func) != ALU_NOP) ||
            bus.Op == OP_ADDI || bus.Op == OP_LW || bus.Op == OP_SW) begin
          state_d = S_EXEC;
        end else if (bus.Op == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (bus.Op == OP_J || bus.Op == OP_JAL) begin
          state_d = S_JUMP;
        end else begin
          ill_op_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        if (op_q == OP_R) begin
          alu_op_c = funct_alu(func_q);
          state_d  = S_WB;
        end else begin
          alu_src_b_c = 2'd2;
          alu_op_c    = ALU_ADD;
          ext_c       = EXT_SIGNED;
          state_d     = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        mem_read_c  = (op_q == OP_LW);
        mem_write_c = (op_q == OP_SW);
        if (bus.mem_ready) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = (op_q == OP_R);
        mem_to_reg_c = (op_q == OP_LW);
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c  = 1'b1;
        alu_op_c     = ALU_SUB;
        ext_c        = EXT_SIGNED;
        pc_src_c     = NPC_BRANCH;
        pc_write_c   = bus.Zero;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c   = 1'b1;
        pc_src_c     = (op_q == OP_JAL) ? NPC_JAL : NPC_JUMP;
        reg_write_c  = (op_q == OP_JAL);
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset already pins state to FETCH; only the mem_ready-driven enables need masking.
  assign bus.PCWrite    = pc_write_c & rst;
  assign bus.IRWrite    = ir_write_c & rst;
  assign bus.MemRead    = mem_read_c;
  assign bus.MemWrite   = mem_write_c;
  assign bus.RegWrite   = reg_write_c;
  assign bus.RegDst     = reg_dst_c;
  assign bus.MemtoReg   = mem_to_reg_c;
  assign bus.ALUSrcA    = alu_src_a_c;
  assign bus.ALUSrcB    = alu_src_b_c;
  assign bus.ALUop      = alu_op_c;
  assign bus.Ext        = ext_c;
  assign bus.PCSrc      = pc_src_c;
  assign bus.state      = 3'(state_q);
  assign bus.instr_done = instr_done_c;
  assign bus.ill_op     = ill_op_c;

endmodule

// File: tb/tb_mc_control.sv
// Directed scoreboard bench for mc_control: per-cycle expected control vectors
// are queued with their stimulus and compared one cycle at a time.
module tb_mc_control;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SRA  = 5'd11;
  localparam logic [1:0] EXT_SIGNED = 2'd1;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JAL    = 2'd3;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_op;
    logic [1:0] ext;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       ill_op;
  } ctl_t;

  typedef struct {
    int         id;
    logic [5:0] op;
    logic [5:0] func;
    logic       mr;
    logic       zero;
    ctl_t       exp;
  } step_t;

  logic  clk = 1'b0;
  logic  rst;
  step_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_id  = 0;

  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic ctl_t sample();
    ctl_t c;
    c.state      = bus.state;
    c.pc_write   = bus.PCWrite;
    c.ir_write   = bus.IRWrite;
    c.mem_read   = bus.MemRead;
    c.mem_write  = bus.MemWrite;
    c.reg_write  = bus.RegWrite;
    c.reg_dst    = bus.RegDst;
    c.mem_to_reg = bus.MemtoReg;
    c.alu_src_a  = bus.ALUSrcA;
    c.alu_src_b  = bus.ALUSrcB;
    c.alu_op     = bus.ALUop;
    c.ext        = bus.Ext;
    c.pc_src     = bus.PCSrc;
    c.instr_done = bus.instr_done;
    c.ill_op     = bus.ill_op;
    return c;
  endfunction

  function automatic ctl_t e_fetch(input logic mr);
    ctl_t c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'd1;
    c.alu_op    = ALU_ADD;
    c.ir_write  = mr;
    c.pc_write  = mr;
    return c;
  endfunction

  function automatic ctl_t e_decode(input logic ill);
    ctl_t c = '0;
    c.state  = 3'd1;
    c.ill_op = ill;
    return c;
  endfunction

  function automatic ctl_t e_exec_r(input logic [4:0] aluop);
    ctl_t c = '0;
    c.state     = 3'd2;
    c.alu_src_a = 1'b1;
    c.alu_op    = aluop;
    return c;
  endfunction

  function automatic ctl_t e_exec_i();
    ctl_t c = '0;
    c.state     = 3'd2;
    c.alu_src_a = 1'b1;
    c.alu_src_b = 2'd2;
    c.alu_op    = ALU_ADD;
    c.ext       = EXT_SIGNED;
    return c;
  endfunction

  function automatic ctl_t e_mem(input logic is_lw, input logic mr);
    ctl_t c = '0;
    c.state      = 3'd3;
    c.mem_read   = is_lw;
    c.mem_write  = !is_lw;
    c.instr_done = !is_lw && mr;
    return c;
  endfunction

  function automatic ctl_t e_wb(input logic dst, input logic m2r);
    ctl_t c = '0;
    c.state      = 3'd4;
    c.reg_write  = 1'b1;
    c.reg_dst    = dst;
    c.mem_to_reg = m2r;
    c.instr_done = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_branch(input logic z);
    ctl_t c = '0;
    c.state      = 3'd5;
    c.alu_src_a  = 1'b1;
    c.alu_op     = ALU_SUB;
    c.ext        = EXT_SIGNED;
    c.pc_src     = NPC_BRANCH;
    c.pc_write   = z;
    c.instr_done = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_jump(input logic jal);
    ctl_t c = '0;
    c.state      = 3'd6;
    c.pc_write   = 1'b1;
    c.reg_write  = jal;
    c.pc_src     = jal ? NPC_JAL : NPC_JUMP;
    c.instr_done = 1'b1;
    return c;
  endfunction

  task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic [5:0] func,
                      input logic mr, input logic zero, input ctl_t exp);
    step_t s;
    s.id = n_id; s.op = op; s.func = func; s.mr = mr; s.zero = zero; s.exp = exp;
    n_id++;
    sb_q.push_back(s);
  endtask

  // Op/Func are scrambled outside DECODE; the controller must ignore them.
  task automatic push_rnd(input logic mr, input logic zero, input ctl_t exp);
    push(6'($urandom), 6'($urandom), mr, zero, exp);
  endtask

  task automatic run_queue();
    step_t s;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      bus.Op        = s.op;
      bus.Func      = s.func;
      bus.mem_ready = s.mr;
      bus.Zero      = s.zero;
      #1;
      check($sformatf("step%0d", s.id), sample(), s.exp);
      @(negedge clk);
    end
  endtask

  initial begin
    rst           = 1'b0;
    bus.Op        = 6'h00;
    bus.Func      = 6'h00;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", sample(), e_fetch(1'b0));
    rst = 1'b1;

    // ADD: states 0,1,2,4; Zero toggled where it must not matter
    push_rnd(1, 0, e_fetch(1));
    push(6'h00, 6'h20, 1, 0, e_decode(0));
    push_rnd(1, 1, e_exec_r(ALU_ADD));
    push_rnd(1, 1, e_wb(1, 0));
    // SUB with a one-cycle fetch stall
    push_rnd(0, 0, e_fetch(0));
    push_rnd(1, 0, e_fetch(1));
    push(6'h00, 6'h22, 1, 0, e_decode(0));
    push_rnd(1, 0, e_exec_r(ALU_SUB));
    push_rnd(1, 0, e_wb(1, 0));
    // SRAV shares the fixed-shift ALU code
    push_rnd(1, 0, e_fetch(1));
    push(6'h00, 6'h07, 1, 0, e_decode(0));
    push_rnd(1, 0, e_exec_r(ALU_SRA));
    push_rnd(1, 0, e_wb(1, 0));
    // ADDI
    push_rnd(1, 0, e_fetch(1));
    push(6'h08, 6'h3F, 1, 0, e_decode(0));
    push_rnd(1, 0, e_exec_i());
    push_rnd(1, 0, e_wb(0, 0));
    // LW with two MEM wait cycles: 7 cycles total
    push_rnd(1, 0, e_fetch(1));
    push(6'h23, 6'h00, 1, 0, e_decode(0));
    push_rnd(1, 0, e_exec_i());
    push_rnd(0, 0, e_mem(1, 0));
    push_rnd(0, 0, e_mem(1, 0));
    push_rnd(1, 0, e_mem(1, 1));
    push_rnd(1, 0, e_wb(0, 1));
    // BEQ taken / not taken
    push_rnd(1, 0, e_fetch(1));
    push(6'h04, 6'h00, 1, 0, e_decode(0));
    push_rnd(1, 1, e_branch(1));
    push_rnd(1, 0, e_fetch(1));
    push(6'h04, 6'h00, 1, 1, e_decode(0));
    push_rnd(1, 0, e_branch(0));
    // JAL then J
    push_rnd(1, 0, e_fetch(1));
    push(6'h03, 6'h00, 1, 0, e_decode(0));
    push_rnd(1, 0, e_jump(1));
    push_rnd(1, 0, e_fetch(1));
    push(6'h02, 6'h00, 1, 0, e_decode(0));
    push_rnd(1, 0, e_jump(0));
    // Illegal opcode, then R-type with illegal funct
    push_rnd(1, 0, e_fetch(1));
    push(6'h3F, 6'h20, 1, 0, e_decode(1));
    push_rnd(1, 0, e_fetch(1));
    push(6'h00, 6'h3F, 1, 0, e_decode(1));
    // SW up to a stalled MEM
    push_rnd(1, 0, e_fetch(1));
    push(6'h2B, 6'h00, 1, 0, e_decode(0));
    push_rnd(1, 0, e_exec_i());
    push_rnd(0, 0, e_mem(0, 0));
    run_queue();

    // Still stalled in MEM; drop reset between clock edges
    bus.mem_ready = 1'b0;
    #1;
    check("sw_stalled", sample(), e_mem(0, 0));
    #2;
    rst           = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("rst_async", sample(), e_fetch(0));
    @(posedge clk);
    #1;
    check("rst_held", sample(), e_fetch(0));
    @(negedge clk);
    rst = 1'b1;

    // Normal ADD after reset release
    push_rnd(1, 0, e_fetch(1));
    push(6'h00, 6'h20, 1, 0, e_decode(0));
    push_rnd(1, 0, e_exec_r(ALU_ADD));
    push_rnd(1, 0, e_wb(1, 0));
    push_rnd(1, 0, e_fetch(1));
    run_queue();

    if (ALU_NOP != 5'd0) $display("note: ALU_NOP nonzero");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
